// File: rtl/waveform_to_pipe_buf_pkg.sv
// Shared types and widths for the waveform-to-pipe capture buffer.
// Covers the capture FSM states and the float/pipe word widths.
package waveform_to_pipe_buf_pkg;

    localparam int unsigned FLOAT_W = 32;
    localparam int unsigned PIPE_W  = 16;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_CAPTURE = 2'd1,
        STATE_DONE    = 2'd2
    } state_e;

    function automatic logic [PIPE_W-1:0] half_word(input logic [FLOAT_W-1:0] s,
                                                    input logic hi);
        return hi ? s[FLOAT_W-1:PIPE_W] : s[PIPE_W-1:0];
    endfunction

endpackage

// File: rtl/waveform_to_pipe_buf_fifo_bram_1r1w.sv
// Simple dual-port RAM, one write port and one read port with a registered
// (1-cycle) read; read-during-write to the same address returns old data.
module waveform_to_pipe_buf_fifo_bram_1r1w #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/waveform_to_pipe_buf.sv
// Capture buffer: records one float sample per sim tick into a BRAM FIFO and
// streams it to the BT pipe-out endpoint as 16-bit words, low half first.
module waveform_to_pipe_buf
    import waveform_to_pipe_buf_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                arm,
    input  logic                sample_valid,
    input  logic [FLOAT_W-1:0]  sample_data,
    input  logic [15:0]         n_samples,
    input  logic                pipe_read,
    output logic [PIPE_W-1:0]   pipe_data,
    output logic                pipe_ready,
    output logic [DEPTH_LOG2:0] level,
    output logic                capture_done,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned BW    = $clog2(BLOCK_WORDS + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_d;
    logic                  empty, full, rd_ok, pop, capturing, wr_en, drop, reached;
    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  half_q, half_d;
    logic [BW-1:0]         blk_q, blk_d;
    logic                  blk_rd, blk_last;
    logic                  ready_q, ready_d, done_q, ovf_q, udf_q;
    logic [DEPTH_LOG2+1:0] avail_d;
    logic [PIPE_W-1:0]     hold_q;
    logic                  byp_q;
    logic [FLOAT_W-1:0]    byp_data_q, bram_rdata, head;

    assign level = wr_ptr_q - rd_ptr_q;

    always_comb begin
        empty     = (level == '0);
        full      = (level == FULL_LEVEL);
        capturing = (state_q == STATE_CAPTURE);
        rd_ok     = pipe_read && !empty;
        pop       = rd_ok && half_q;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en     = capturing && sample_valid && (!full || pop) && !clear;
        drop      = capturing && sample_valid && full && !pop;

        wr_ptr_d  = wr_ptr_q + (DEPTH_LOG2+1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (DEPTH_LOG2+1)'(pop);
        half_d    = half_q ^ rd_ok;
        level_d   = wr_ptr_d - rd_ptr_d;

        cnt_d = cnt_q;
        if (arm) begin
            cnt_d = '0;
        end else if (wr_en) begin
            cnt_d = cnt_q + 16'd1;
        end

        reached = (n_samples != '0) ? (wr_en && (cnt_d == n_samples))
                                    : (level_d == FULL_LEVEL);
        state_d = state_q;
        case (state_q)
            STATE_IDLE:    if (arm) state_d = STATE_CAPTURE;
            STATE_CAPTURE: if (!arm && reached) state_d = STATE_DONE;
            STATE_DONE:    if (arm) state_d = STATE_CAPTURE;
            default:       state_d = STATE_IDLE;
        endcase

        // ready is held through a whole block and only re-evaluated at its end
        blk_rd   = ready_q && rd_ok;
        blk_last = (32'(blk_q) == BLOCK_WORDS - 1);
        blk_d    = blk_q;
        if (blk_rd) begin
            blk_d = blk_last ? '0 : blk_q + BW'(1);
        end
        avail_d = {level_d, 1'b0} - (DEPTH_LOG2+2)'(half_d);
        ready_d = (ready_q && !(blk_rd && blk_last)) || (32'(avail_d) >= BLOCK_WORDS);
    end

    waveform_to_pipe_buf_fifo_bram_1r1w #(
        .AW(DEPTH_LOG2),
        .DW(FLOAT_W)
    ) u_fifo (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (sample_data),
        .raddr_i (rd_ptr_d[DEPTH_LOG2-1:0]),
        .rdata_o (bram_rdata)
    );

    // BRAM reads the next head address every cycle; a write landing on that
    // address is forwarded so the head register is never stale
    assign head      = byp_q ? byp_data_q : bram_rdata;
    assign pipe_data = empty ? hold_q : half_word(head, half_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= STATE_IDLE;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            blk_q      <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            hold_q     <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else if (clear) begin
            state_q    <= STATE_IDLE;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            blk_q      <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            hold_q     <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_d == STATE_DONE);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            blk_q      <= blk_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_q | drop;
            udf_q      <= udf_q | (pipe_read && empty);
            hold_q     <= pipe_data;
            byp_q      <= wr_en && (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
            byp_data_q <= sample_data;
        end
    end

    assign pipe_ready   = ready_q;
    assign capture_done = done_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_waveform_to_pipe_buf.sv
// Self-checking bench for waveform_to_pipe_buf: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_waveform_to_pipe_buf;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BLK   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear, arm, sample_valid, pipe_read;
    logic [31:0] sample_data;
    logic [15:0] n_samples;
    logic [15:0] pipe_data;
    logic        pipe_ready, capture_done, overflow, underflow;
    logic [DL2:0] level;

    waveform_to_pipe_buf #(
        .DEPTH_LOG2  (DL2),
        .BLOCK_WORDS (BLK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .arm          (arm),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .n_samples    (n_samples),
        .pipe_read    (pipe_read),
        .pipe_data    (pipe_data),
        .pipe_ready   (pipe_ready),
        .level        (level),
        .capture_done (capture_done),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_fail = 0;
    string phase = "reset";

    // reference model state
    logic [31:0] mq [$];
    bit          m_half, m_cap, m_done, m_ovf, m_udf, m_ready;
    int          m_cnt, m_blk;
    logic [15:0] m_pd;

    logic [31:0] t1_in  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [15:0] t1_out [8] = '{16'h0000, 16'h3F80, 16'h0000, 16'h4000,
                                16'h0000, 16'h4040, 16'h0000, 16'h4080};
    logic [31:0] t3_vals [4];
    logic [31:0] tmp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h, expected %h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_half = 0; m_cap = 0; m_done = 0; m_ovf = 0; m_udf = 0; m_ready = 0;
        m_cnt = 0; m_blk = 0; m_pd = '0;
    endtask

    task automatic model_step(input bit clr, input bit a, input bit sv,
                              input logic [31:0] sd, input bit rd);
        bit rd_ok, pop, acc, blk_end;
        int words;
        if (clr) begin
            model_clear();
            return;
        end
        rd_ok = rd && (mq.size() != 0);
        pop   = rd_ok && m_half;
        if (rd && mq.size() == 0) m_udf = 1;
        acc = 0;
        if (m_cap && sv) begin
            if (mq.size() < DEPTH || pop) acc = 1;
            else m_ovf = 1;
        end
        blk_end = 0;
        if (m_ready && rd_ok) begin
            m_blk++;
            if (m_blk == int'(BLK)) begin
                m_blk = 0;
                blk_end = 1;
            end
        end
        if (rd_ok) begin
            if (m_half) begin
                void'(mq.pop_front());
                m_half = 0;
            end else begin
                m_half = 1;
            end
        end
        if (acc) begin
            mq.push_back(sd);
            m_cnt++;
        end
        if (a) begin
            m_cap = 1; m_done = 0; m_cnt = 0;
        end else if (m_cap && ((n_samples != 0 && acc && m_cnt == int'(n_samples)) ||
                               (n_samples == 0 && mq.size() == DEPTH))) begin
            m_cap = 0; m_done = 1;
        end
        words   = 2 * mq.size() - int'(m_half);
        m_ready = (m_ready && !blk_end) || (words >= int'(BLK));
        if (mq.size() != 0) begin
            tmp  = mq[0];
            m_pd = m_half ? tmp[31:16] : tmp[15:0];
        end
    endtask

    task automatic check_all();
        chk("pipe_data",    32'(pipe_data),    32'(m_pd));
        chk("pipe_ready",   32'(pipe_ready),   32'(m_ready));
        chk("level",        32'(level),        mq.size());
        chk("capture_done", 32'(capture_done), 32'(m_done));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
    endtask

    // called at a negedge: drive, let the posedge happen, check at the next negedge
    task automatic tick(input bit clr, input bit a, input bit sv,
                        input logic [31:0] sd, input bit rd);
        clear = clr; arm = a; sample_valid = sv; sample_data = sd; pipe_read = rd;
        @(posedge clk);
        model_step(clr, a, sv, sd, rd);
        @(negedge clk);
        clear = 0; arm = 0; sample_valid = 0; pipe_read = 0;
        check_all();
    endtask

    initial begin
        reset_n = 0; clear = 0; arm = 0; sample_valid = 0; sample_data = '0;
        n_samples = '0; pipe_read = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1;
        @(negedge clk);
        check_all();

        // 1: four samples, eight words out low half first
        phase = "t1";
        n_samples = 16'd4;
        tick(0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, t1_in[i], 0);
        chk("t1_done", 32'(capture_done), 32'd1);
        chk("t1_level", 32'(level), 32'd4);
        for (int i = 0; i < 8; i++) begin
            chk("t1_word", 32'(pipe_data), 32'(t1_out[i]));
            tick(0, 0, 0, '0, 1);
        end

        // 2: capture until full, later strobes ignored
        phase = "t2";
        tick(1, 0, 0, '0, 0);
        n_samples = 16'd0;
        tick(0, 1, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 1, $urandom, 0);
            if (i == 15) chk("t2_done16", 32'(capture_done), 32'd1);
        end
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_ovf", 32'(overflow), 32'd0);
        tick(1, 0, 0, '0, 0);
        chk("t2_clr_level", 32'(level), 32'd0);

        // 3: ready threshold and back-to-back block read
        phase = "t3";
        n_samples = 16'd100;
        tick(0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) t3_vals[i] = $urandom;
        for (int i = 0; i < 3; i++) tick(0, 0, 1, t3_vals[i], 0);
        chk("t3_ready3", 32'(pipe_ready), 32'd0);
        tick(0, 0, 1, t3_vals[3], 0);
        chk("t3_ready4", 32'(pipe_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tmp = t3_vals[i/2];
            chk("t3_word", 32'(pipe_data), (i % 2 == 1) ? 32'(tmp[31:16]) : 32'(tmp[15:0]));
            tick(0, 0, 0, '0, 1);
        end
        chk("t3_ready_end", 32'(pipe_ready), 32'd0);
        chk("t3_level_end", 32'(level), 32'd0);

        // 4: full FIFO, overflow vs write-with-pop
        phase = "t4";
        tick(1, 0, 0, '0, 0);
        n_samples = 16'd100;
        tick(0, 1, 0, '0, 0);
        for (int i = 0; i < 16; i++) tick(0, 0, 1, $urandom, 0);
        chk("t4_full", 32'(level), 32'd16);
        tick(0, 0, 1, 32'hDEADBEEF, 0);
        chk("t4_ovf", 32'(overflow), 32'd1);
        tick(0, 0, 0, '0, 1);
        tick(0, 0, 1, 32'hCAFEF00D, 1);
        chk("t4_level_pop", 32'(level), 32'd16);
        for (int i = 0; i < 32; i++) tick(0, 0, 0, '0, 1);

        // 5: underflow holds pipe_data, pointers intact afterwards
        phase = "t5";
        tick(1, 0, 0, '0, 0);
        n_samples = 16'd1;
        tick(0, 1, 0, '0, 0);
        tick(0, 0, 1, 32'hAABBCCDD, 0);
        tick(0, 0, 0, '0, 1);
        tick(0, 0, 0, '0, 1);
        chk("t5_hold", 32'(pipe_data), 32'h0000AABB);
        tick(0, 0, 0, '0, 1);
        chk("t5_udf", 32'(underflow), 32'd1);
        chk("t5_hold_udf", 32'(pipe_data), 32'h0000AABB);
        tick(0, 1, 0, '0, 0);
        tick(0, 0, 1, 32'h12345678, 0);
        chk("t5_lo", 32'(pipe_data), 32'h00005678);
        tick(0, 0, 0, '0, 1);
        chk("t5_hi", 32'(pipe_data), 32'h00001234);
        tick(0, 0, 0, '0, 1);

        // 6: asynchronous reset pulse mid-read
        phase = "t6";
        tick(1, 0, 0, '0, 0);
        n_samples = 16'd4;
        tick(0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, $urandom, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, '0, 1);
        #2 reset_n = 0;
        #1 reset_n = 1;
        model_clear();
        #1;
        check_all();
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_pd", 32'(pipe_data), 32'd0);
        @(negedge clk);
        n_samples = 16'd2;
        tick(0, 1, 0, '0, 0);
        tick(0, 0, 1, 32'h01020304, 0);
        tick(0, 0, 1, 32'h05060708, 0);
        chk("t6_done", 32'(capture_done), 32'd1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, '0, 1);

        // randomized traffic
        phase = "rand";
        for (int i = 0; i < 600; i++) begin
            bit c, a, sv, rd;
            c  = ($urandom_range(0, 99) == 0);
            a  = ($urandom_range(0, 19) == 0);
            sv = ($urandom_range(0, 1) == 1);
            rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (a) n_samples = 16'($urandom_range(0, 24));
            tick(c, a, sv, $urandom, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
